framed_bit_tx: RTL

Framed serial bit transmitter. It accepts parallel data words over a valid/ready handshake and emits each word as a serial frame on a single bit line, one bit per bit-enable tick. Each frame is a sync pattern, then the data MSB-first, then an optional even-parity bit. It is the transmit end of the serial link whose receiver is the team's sequence-detector state machine, and it sits between a word source (typically the synchronous FIFO read side) and the serial line.

---
 rtl/framed_bit_tx_if.sv | 11 +
 rtl/framed_bit_tx.sv | 126 ++++++++++++
 2 files changed

// File: rtl/framed_bit_tx_if.sv
// Word handshake between a word source and the framed bit transmitter.
interface framed_bit_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/framed_bit_tx.sv
// Framed serial bit transmitter: sync pattern, data MSB-first, optional
// even parity, one bit per bit_en tick, with back-to-back frame handoff.
module framed_bit_tx #(
    parameter int unsigned         DATA_WIDTH   = 8,
    parameter int unsigned         SYNC_LEN     = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1101,
    parameter bit                  PARITY_EN    = 1'b1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           bit_en,
    framed_bit_tx_if.slave in_if,
    output logic           tx_bit,
    output logic           tx_valid,
    output logic           busy,
    output logic           frame_done
);
    localparam int unsigned MAX_LEN = (SYNC_LEN > DATA_WIDTH) ? SYNC_LEN : DATA_WIDTH;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned FRAME_W = SYNC_LEN + DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PARITY
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Sync pattern and data share one shift register; its MSB is the current bit.
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               par_q, par_d;
    logic               tx_bit_q, tx_bit_d;
    logic               tx_valid_q, tx_valid_d;
    logic               done_q, done_d;

    logic sync_last;
    logic data_last;
    logic frame_end;
    logic accept;

    assign sync_last = (cnt_q == CNT_W'(SYNC_LEN - 1));
    assign data_last = (cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign frame_end = bit_en &&
                       ((state_q == ST_PARITY) ||
                        ((state_q == ST_DATA) && data_last && !PARITY_EN));

    assign in_if.in_ready = rstn && ((state_q == ST_IDLE) || frame_end);
    assign accept         = in_if.in_valid && in_if.in_ready;

    assign tx_bit     = tx_bit_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = tx_valid_q;
    assign frame_done = done_q;

    // Next-state, shift and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        unique case (state_q)
            ST_IDLE: ;
            ST_SYNC: begin
                if (bit_en) begin
                    shreg_d = shreg_q << 1;
                    if (sync_last) begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (bit_en) begin
                    shreg_d = shreg_q << 1;
                    if (data_last) begin
                        state_d = PARITY_EN ? ST_PARITY : ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A word accepted on the last-bit cycle overrides the return to idle.
        if (accept) begin
            state_d = ST_SYNC;
            cnt_d   = '0;
            shreg_d = {SYNC_PATTERN, in_if.in_data};
            par_d   = ^in_if.in_data;
        end
        tx_valid_d = (state_d != ST_IDLE);
        tx_bit_d   = (state_d == ST_PARITY) ? par_d : (tx_valid_d & shreg_d[FRAME_W-1]);
        done_d     = frame_end;
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tx_bit_q   <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tx_bit_q   <= tx_bit_d;
            tx_valid_q <= tx_valid_d;
            done_q     <= done_d;
        end
    end
endmodule
